// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns EX/MEM load/store controls into a req/ack
// data-memory transaction, formats load data for write-back and stalls the pipeline meanwhile.
module mem_stage_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    input  logic [WIDTH-1:0] AluResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] DmemRData,
    input  logic             DmemAck,
    output logic             DmemReq,
    output logic             DmemWe,
    output logic [WIDTH-1:0] DmemAddr,
    output logic [WIDTH-1:0] DmemWData,
    output logic [3:0]       DmemBe,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             MisalignM,
    output logic             BusErrM,
    output logic [1:0]       LsuState
);

    // Handshake: DmemReq rises with We/Addr/WData/Be and all of them hold until the
    // single-cycle DmemAck strobe (or the timeout); an ack seen outside REQ is ignored.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsuState_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    lsuState_t        state;
    lsuState_t        stateNext;
    logic [CW-1:0]    timeoutCnt;
    logic [2:0]       ldFunct3;
    logic [1:0]       ldOff;

    logic             access;
    logic             funct3Legal;
    logic             aligned;
    logic             legal;
    logic             startAcc;
    logic             ackDone;
    logic             toDone;
    logic [3:0]       stBe;
    logic [WIDTH-1:0] stWData;
    logic [7:0]       ldByte;
    logic [15:0]      ldHalf;
    logic [WIDTH-1:0] loadData;

    assign access   = MemReadM | MemWriteM;
    assign LsuState = state;

    // A simultaneous read and write is treated as a store, so legality follows MemWriteM.
    always_comb begin
        funct3Legal = 1'b0;
        case (Funct3M)
            3'b000, 3'b001, 3'b010: funct3Legal = 1'b1;
            3'b100, 3'b101:         funct3Legal = ~MemWriteM;
            default:                funct3Legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (Funct3M[1:0])
            2'b01:   aligned = ~AluResultM[0];
            2'b10:   aligned = (AluResultM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal = funct3Legal & aligned;

    always_comb begin
        stBe    = 4'b1111;
        stWData = '0;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    stBe    = 4'b0001 << AluResultM[1:0];
                    stWData = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    stBe    = 4'b0011 << AluResultM[1:0];
                    stWData = {2{WriteDataM[15:0]}};
                end
                default: begin
                    stBe    = 4'b1111;
                    stWData = WriteDataM;
                end
            endcase
        end
    end

    assign ldByte = DmemRData[{ldOff, 3'b000} +: 8];
    assign ldHalf = DmemRData[{ldOff[1], 4'b0000} +: 16];

    always_comb begin
        loadData = DmemRData;
        case (ldFunct3)
            3'b000:  loadData = {{(WIDTH-8){ldByte[7]}}, ldByte};
            3'b001:  loadData = {{(WIDTH-16){ldHalf[15]}}, ldHalf};
            3'b100:  loadData = {{(WIDTH-8){1'b0}}, ldByte};
            3'b101:  loadData = {{(WIDTH-16){1'b0}}, ldHalf};
            default: loadData = DmemRData;
        endcase
    end

    always_comb begin
        stateNext = state;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        startAcc  = 1'b0;
        ackDone   = 1'b0;
        toDone    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        StallM    = 1'b1;
                        startAcc  = 1'b1;
                        stateNext = REQ;
                    end else begin
                        MisalignM = 1'b1;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                // An ack landing on the last wait cycle still completes normally.
                if (DmemAck) begin
                    ackDone   = 1'b1;
                    stateNext = DONE;
                end else if (timeoutCnt == LAST_WAIT) begin
                    toDone    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            timeoutCnt <= '0;
            DmemReq    <= 1'b0;
            DmemWe     <= 1'b0;
            DmemAddr   <= '0;
            DmemWData  <= '0;
            DmemBe     <= 4'b0000;
            ReadDataM  <= '0;
            BusErrM    <= 1'b0;
            ldFunct3   <= 3'b000;
            ldOff      <= 2'b00;
        end else begin
            state      <= stateNext;
            BusErrM    <= toDone;
            timeoutCnt <= (state == REQ && stateNext == REQ) ? timeoutCnt + 1'b1 : '0;
            if (startAcc) begin
                DmemReq   <= 1'b1;
                DmemWe    <= MemWriteM;
                DmemAddr  <= {AluResultM[WIDTH-1:2], 2'b00};
                DmemWData <= stWData;
                DmemBe    <= stBe;
                ldFunct3  <= Funct3M;
                ldOff     <= AluResultM[1:0];
            end
            if (ackDone) begin
                DmemReq   <= 1'b0;
                ReadDataM <= DmemWe ? '0 : loadData;
            end
            if (toDone) begin
                DmemReq   <= 1'b0;
                ReadDataM <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a driver plays the pipeline and the memory
// responder, while two monitors check bus requests and write-back results from expected queues.
module tb_mem_stage_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AluResultM;
    logic [31:0] WriteDataM;
    logic [31:0] DmemRData;
    logic        DmemAck;
    logic        DmemReq;
    logic        DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWData;
    logic [3:0]  DmemBe;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic [1:0]  LsuState;

    int n_checks = 0;
    int n_fail   = 0;
    int buserr_cycles = 0;

    // {We, Addr, WData, Be} per request; {BusErr, ReadData} per completion
    logic [68:0] exp_req_q[$];
    logic [32:0] exp_rsp_q[$];
    logic [68:0] req_hold;
    logic        req_prev = 1'b0;

    mem_stage_lsu #(.WIDTH(32), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .AluResultM(AluResultM), .WriteDataM(WriteDataM),
        .DmemRData(DmemRData), .DmemAck(DmemAck),
        .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr),
        .DmemWData(DmemWData), .DmemBe(DmemBe), .ReadDataM(ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .LsuState(LsuState)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request monitor: compares each new request and checks it holds steady while pending.
    always @(negedge CLK) begin
        logic [68:0] e;
        logic [68:0] a;
        if (!RST) begin
            a = {DmemWe, DmemAddr, DmemWData, DmemBe};
            if (DmemReq && !req_prev) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", a, 69'h0);
                end else begin
                    e = exp_req_q.pop_front();
                    if (!e[68]) a[35:4] = 32'h0;
                    check("req_fields", a, e);
                end
                req_hold = {DmemWe, DmemAddr, DmemWData, DmemBe};
            end else if (DmemReq && req_prev) begin
                check("req_stable", {DmemWe, DmemAddr, DmemWData, DmemBe}, req_hold);
            end
        end
        req_prev = DmemReq;
    end

    // Completion monitor: the result is presented while the unit sits in DONE.
    always @(negedge CLK) begin
        logic [32:0] e;
        if (BusErrM) buserr_cycles++;
        if (!RST && LsuState == 2'd2) begin
            if (exp_rsp_q.size() == 0) begin
                check("unexpected_rsp", {36'h0, BusErrM, ReadDataM}, 69'h1_FFFF_FFFF);
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_result", {36'h0, BusErrM, ReadDataM}, {36'h0, e});
            end
        end
    end

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        AluResultM = 32'h0;
        WriteDataM = 32'h0;
        DmemAck    = 1'b0;
        DmemRData  = 32'hBAD0BAD0;
    endtask

    // Holds the instruction in MEM until StallM drops; acks after ack_wait pending cycles.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int ack_wait, input logic exp_mis,
                             input int exp_stall, input int exp_req);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int waited    = 0;
        bit done      = 0;
        logic mis     = 1'b0;
        @(posedge CLK); #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        AluResultM = addr;
        WriteDataM = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge CLK);
            DmemAck   = 1'b0;
            DmemRData = 32'hBAD0BAD0;
            if (cyc == 0) mis = MisalignM;
            if (DmemReq) begin
                req_cnt++;
                if (waited == ack_wait) begin
                    DmemAck   = 1'b1;
                    DmemRData = rdata;
                end
                waited++;
            end
            if (StallM) stall_cnt++;
            else done = 1;
        end
        if (!done) check({name, "_stall_bound"}, 69'd0, 69'd1);
        check({name, "_misalign"}, {68'h0, mis}, {68'h0, exp_mis});
        check({name, "_stall_cycles"}, 69'(stall_cnt), 69'(exp_stall));
        check({name, "_req_cycles"}, 69'(req_cnt), 69'(exp_req));
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_bus", {DmemReq, DmemWe, DmemAddr, DmemWData, DmemBe},
              {1'b0, 1'b0, 32'h0, 32'h0, 4'h0});
        check("reset_misc", {63'h0, ReadDataM == 32'h0, BusErrM, LsuState, StallM, MisalignM},
              {63'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        RST = 1'b0;

        exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
        do_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 2, 1);

        exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'hFFFF_FF80});
        do_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 2, 1);

        exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0000_0080});
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 2, 1);

        exp_req_q.push_back({1'b1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100});
        exp_rsp_q.push_back({1'b0, 32'h0});
        do_access("sh", 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 2, 1);

        do_access("lw_misaligned", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 0, 0);
        do_access("funct3_011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 0, 0);
        do_access("store_f3_100", 0, 1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 1, 0, 0);
        do_access("sh_odd", 0, 1, 3'b001, 32'h203, 32'h1234, 32'h0, 0, 1, 0, 0);

        exp_req_q.push_back({1'b1, 32'h0000_0300, 32'h7878_7878, 4'b0010});
        exp_rsp_q.push_back({1'b0, 32'h0});
        do_access("sb_wait2", 0, 1, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 2, 0, 4, 3);

        exp_req_q.push_back({1'b1, 32'h0000_0404, 32'hCAFE_F00D, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0});
        do_access("sw", 0, 1, 3'b010, 32'h404, 32'hCAFE_F00D, 32'h0, 1, 0, 3, 2);

        exp_req_q.push_back({1'b0, 32'h0000_0104, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'hFFFF_8001});
        do_access("lh_hi", 1, 0, 3'b001, 32'h106, 32'h0, 32'h8001_7FFF, 0, 0, 2, 1);

        exp_req_q.push_back({1'b0, 32'h0000_0104, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0000_8001});
        do_access("lhu_hi", 1, 0, 3'b101, 32'h106, 32'h0, 32'h8001_7FFF, 0, 0, 2, 1);

        exp_req_q.push_back({1'b0, 32'h0000_0104, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0000_7FFF});
        do_access("lh_lo", 1, 0, 3'b001, 32'h104, 32'h0, 32'h8001_7FFF, 0, 0, 2, 1);

        exp_req_q.push_back({1'b1, 32'h0000_0600, 32'h1122_3344, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0});
        do_access("rd_wr_store", 1, 1, 3'b010, 32'h600, 32'h1122_3344, 32'h9999_9999, 0, 0, 2, 1);

        exp_req_q.push_back({1'b0, 32'h0000_0700, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0000_0042});
        do_access("ack_last_cycle", 1, 0, 3'b100, 32'h700, 32'h0, 32'h0000_0042, 15, 0, 17, 16);

        exp_req_q.push_back({1'b0, 32'h0000_0800, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b1, 32'h0});
        do_access("lh_timeout", 1, 0, 3'b001, 32'h802, 32'h0, 32'h0, 99, 0, 17, 16);

        // Reset while a request is pending, then a stray ack.
        exp_req_q.push_back({1'b0, 32'h0000_0500, 32'h0, 4'b1111});
        exp_rsp_q.push_back({1'b0, 32'h0000_0077});
        do_access("lw_before_rst", 1, 0, 3'b010, 32'h500, 32'h0, 32'h0000_0077, 0, 0, 2, 1);
        exp_req_q.push_back({1'b0, 32'h0000_0500, 32'h0, 4'b1111});
        @(posedge CLK); #1;
        MemReadM   = 1'b1;
        Funct3M    = 3'b010;
        AluResultM = 32'h500;
        repeat (4) @(negedge CLK);
        RST      = 1'b1;
        MemReadM = 1'b0;
        @(negedge CLK);
        check("rst_in_req", {65'h0, DmemReq, LsuState, StallM}, {65'h0, 1'b0, 2'd0, 1'b0});
        RST       = 1'b0;
        DmemAck   = 1'b1;
        DmemRData = 32'h1234_5678;
        @(negedge CLK);
        DmemAck = 1'b0;
        check("stray_ack", {35'h0, ReadDataM, LsuState}, {35'h0, 32'h0, 2'd0});
        repeat (3) @(negedge CLK);

        check("buserr_pulses", 69'(buserr_cycles), 69'd1);
        check("req_queue_empty", 69'(exp_req_q.size()), 69'd0);
        check("rsp_queue_empty", 69'(exp_rsp_q.size()), 69'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
